ir_prefetch: RTL

- Parametrised successor to the single-byte instruction register: a DEPTH-entry prefetch queue in front of decode that assembles multi-byte instructions (opcode plus up to MAX_OPERANDS operand bytes).
- Sits between the bus and the control unit. Bytes are pushed from the bus as they are fetched. Decode sees a complete opcode+operand bundle only when every byte of it is present, and retires the bundle in one cycle.
- Operand length is supplied combinationally by the external length decoder from head_byte.

---
 rtl/ir_prefetch.sv | 92 +++++++++
 1 files changed

// File: rtl/ir_prefetch.sv
// Prefetch queue in front of decode: a DEPTH-entry circular byte buffer that
// presents a complete opcode+operand bundle once all of its bytes are queued.
module ir_prefetch #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int MAX_OPERANDS = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 we,
    input  logic [WIDTH-1:0]                     bus,
    input  logic                                 flush,
    output logic [WIDTH-1:0]                     head_byte,
    input  logic [$clog2(MAX_OPERANDS+1)-1:0]    head_len,
    output logic                                 instr_valid,
    output logic [WIDTH-1:0]                     opcode,
    output logic [MAX_OPERANDS*WIDTH-1:0]        operands,
    input  logic                                 instr_ack,
    output logic [$clog2(DEPTH+1)-1:0]           count,
    output logic                                 full,
    output logic                                 empty,
    output logic                                 overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(MAX_OPERANDS + 1);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_OPERANDS);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rp;
    logic [PW-1:0]    wp;

    logic [LW-1:0]    eff_len;
    logic [CW-1:0]    bundle_len;
    logic [CW-1:0]    pop_len;
    logic             push_ok;
    logic             pop;

    // full is taken from the registered count, so a same-cycle pop never
    // makes room for a push arriving while the queue is full.
    always_comb begin
        eff_len     = (head_len > MAX_LEN) ? MAX_LEN : head_len;
        bundle_len  = CW'(eff_len) + CW'(1);
        instr_valid = (count >= bundle_len);
        full        = (count == DEPTH_C);
        empty       = (count == '0);
        push_ok     = we && !full;
        pop         = instr_ack && instr_valid;
        pop_len     = pop ? bundle_len : '0;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rp       <= '0;
            wp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wp <= wp + PW'(1);
            end
            if (we && full) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rp <= rp + PW'(bundle_len);
            end
            count <= count + CW'(push_ok) - pop_len;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && push_ok) begin
            mem[wp] <= bus;
        end
    end

    always_comb begin
        head_byte = empty ? '0 : mem[rp];
        opcode    = instr_valid ? mem[rp] : '0;
        operands  = '0;
        for (int unsigned k = 0; k < MAX_OPERANDS; k++) begin
            if (instr_valid && (LW'(k) < eff_len)) begin
                operands[k*WIDTH +: WIDTH] = mem[rp + PW'(k + 1)];
            end
        end
    end

endmodule
